// File: rtl/snoop_responder_if.sv
// Shared types and the fabric-facing snoop channel bundle for snoop_responder.
// master: snoop fabric side, slave: the responder.
package snoop_responder_pkg;
    localparam int ADDR_WIDTH = 64;
    localparam int LINE_WIDTH = 128;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            snoop;
        logic [2:0]            prot;
    } ac_chan_t;

    // {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    typedef logic [4:0] cr_chan_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic                  last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_chan_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_DATA   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RESP   = 3'd4,
        ST_CDATA  = 3'd5
    } state_t;

    localparam logic [1:0] UPD_NONE   = 2'b00;
    localparam logic [1:0] UPD_SHARED = 2'b01;
    localparam logic [1:0] UPD_INVAL  = 2'b10;
endpackage

interface snoop_responder_if;
    import snoop_responder_pkg::*;

    // Every channel: a transfer happens on a cycle where valid and ready are both
    // high; valid never drops before that and the payload is held while valid.
    snoop_req_t  snoop_req;
    snoop_resp_t snoop_resp;

    modport master (output snoop_req, input snoop_resp);
    modport slave  (input snoop_req, output snoop_resp);
endinterface

// File: rtl/snoop_responder.sv
// ACE snoop terminator: AC request -> tag lookup -> optional line read -> state update -> CR -> CD.
// Build option SNOOP_RESPONDER_ERR_EN: reserved snoop codes answer with the Error bit set.
module snoop_responder
    import snoop_responder_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int LineWidth = LINE_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    snoop_responder_if.slave     snoop_bus,
    output logic                 lookup_req_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_unique_i,
    output logic                 data_req_o,
    input  logic                 data_valid_i,
    input  logic [LineWidth-1:0] data_i,
    output logic                 upd_req_o,
    output logic [1:0]           upd_op_o,
    input  logic                 upd_gnt_i,
    output logic                 busy_o,
    output state_t               dbg_state_o
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ac_ready;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_snoop;
    cr_chan_t             r_cr;
    logic [1:0]           r_upd_op;
    logic [LineWidth-1:0] r_data;

    logic                 w_ac_hs;
    logic                 w_dec_reserved;
    logic                 w_dec_data;
    logic                 w_dec_shared;
    logic                 w_dec_pass_dirty;
    logic [1:0]           w_dec_op;
    logic                 w_look_data;
    logic [1:0]           w_look_op;
    cr_chan_t             w_look_cr;
    snoop_resp_t          w_resp;

    assign w_ac_hs = (r_state == ST_IDLE) && r_ac_ready && snoop_bus.snoop_req.ac_valid;

    // Snoop-code decode assuming a hit; miss and reserved handling is applied below.
    always_comb begin
        w_dec_reserved   = 1'b0;
        w_dec_data       = 1'b0;
        w_dec_shared     = 1'b0;
        w_dec_pass_dirty = 1'b0;
        w_dec_op         = UPD_NONE;
        case (r_snoop)
            4'b0000: begin
                w_dec_data   = 1'b1;
                w_dec_shared = 1'b1;
            end
            4'b0001, 4'b0010, 4'b0011: begin
                w_dec_data       = 1'b1;
                w_dec_shared     = 1'b1;
                w_dec_pass_dirty = lookup_dirty_i;
                w_dec_op         = UPD_SHARED;
            end
            4'b0111: begin
                w_dec_data       = 1'b1;
                w_dec_pass_dirty = lookup_dirty_i;
                w_dec_op         = UPD_INVAL;
            end
            4'b1001: begin
                w_dec_data       = lookup_dirty_i;
                w_dec_pass_dirty = lookup_dirty_i;
                w_dec_op         = UPD_INVAL;
            end
            4'b1000: begin
                w_dec_data       = lookup_dirty_i;
                w_dec_shared     = 1'b1;
                w_dec_pass_dirty = lookup_dirty_i;
                w_dec_op         = UPD_SHARED;
            end
            4'b1101: begin
                w_dec_op = UPD_INVAL;
            end
            default: begin
                w_dec_reserved = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_look_data = 1'b0;
        w_look_op   = UPD_NONE;
        w_look_cr   = 5'b0;
        if (w_dec_reserved) begin
`ifdef SNOOP_RESPONDER_ERR_EN
            w_look_cr = 5'b00010;
`else
            w_look_cr = 5'b00000;
`endif
        end else if (lookup_hit_i) begin
            w_look_data = w_dec_data;
            w_look_op   = w_dec_op;
            w_look_cr   = {lookup_unique_i, w_dec_shared, w_dec_pass_dirty, 1'b0, w_dec_data};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ac_ready <= 1'b0;
            r_addr     <= '0;
            r_snoop    <= 4'b0;
            r_cr       <= 5'b0;
            r_upd_op   <= UPD_NONE;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ac_ready <= (w_state_nxt == ST_IDLE);
            if (w_ac_hs) begin
                r_addr  <= snoop_bus.snoop_req.ac.addr;
                r_snoop <= snoop_bus.snoop_req.ac.snoop;
            end
            if ((r_state == ST_LOOKUP) && lookup_valid_i) begin
                r_cr     <= w_look_cr;
                r_upd_op <= w_look_op;
            end
            if ((r_state == ST_DATA) && data_valid_i) begin
                r_data <= data_i;
            end
        end
    end

    // Data read is always ordered ahead of the update so an invalidate never drops a dirty line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ac_hs) w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lookup_valid_i) begin
                    if (w_look_data)                w_state_nxt = ST_DATA;
                    else if (w_look_op != UPD_NONE) w_state_nxt = ST_UPDATE;
                    else                            w_state_nxt = ST_RESP;
                end
            end
            ST_DATA: begin
                if (data_valid_i) begin
                    w_state_nxt = (r_upd_op != UPD_NONE) ? ST_UPDATE : ST_RESP;
                end
            end
            ST_UPDATE: begin
                if (upd_gnt_i) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (snoop_bus.snoop_req.cr_ready) begin
                    w_state_nxt = r_cr[0] ? ST_CDATA : ST_IDLE;
                end
            end
            ST_CDATA: begin
                if (snoop_bus.snoop_req.cd_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_resp          = '0;
        w_resp.ac_ready = r_ac_ready;
        w_resp.cr_valid = (r_state == ST_RESP);
        w_resp.cr_resp  = r_cr;
        w_resp.cd_valid = (r_state == ST_CDATA);
        w_resp.cd.data  = r_data;
        w_resp.cd.last  = (r_state == ST_CDATA);
    end

    assign snoop_bus.snoop_resp = w_resp;
    assign lookup_req_o         = (r_state == ST_LOOKUP);
    assign lookup_addr_o        = r_addr;
    assign data_req_o           = (r_state == ST_DATA);
    assign upd_req_o            = (r_state == ST_UPDATE);
    assign upd_op_o             = (r_state == ST_UPDATE) ? r_upd_op : UPD_NONE;
    assign busy_o               = (r_state != ST_IDLE);
    assign dbg_state_o          = r_state;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with a zero-wait cache model and ready snoop channels.
module tb_snoop_responder;
    import snoop_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snoop_responder_if bus();

    logic          lookup_req, lookup_valid, lookup_hit, lookup_dirty, lookup_unique;
    logic [63:0]   lookup_addr;
    logic          data_req, data_valid, upd_req, upd_gnt, busy;
    logic [127:0]  data_line;
    logic [1:0]    upd_op;
    state_t        dbg_state;

    logic          m_hit, m_dirty, m_unique;
    logic [127:0]  m_data;

    assign lookup_valid  = lookup_req;
    assign lookup_hit    = m_hit;
    assign lookup_dirty  = m_dirty;
    assign lookup_unique = m_unique;
    assign data_valid    = data_req;
    assign data_line     = m_data;
    assign upd_gnt       = upd_req;

    snoop_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .snoop_bus       (bus.slave),
        .lookup_req_o    (lookup_req),
        .lookup_addr_o   (lookup_addr),
        .lookup_valid_i  (lookup_valid),
        .lookup_hit_i    (lookup_hit),
        .lookup_dirty_i  (lookup_dirty),
        .lookup_unique_i (lookup_unique),
        .data_req_o      (data_req),
        .data_valid_i    (data_valid),
        .data_i          (data_line),
        .upd_req_o       (upd_req),
        .upd_op_o        (upd_op),
        .upd_gnt_i       (upd_gnt),
        .busy_o          (busy),
        .dbg_state_o     (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction observations, cycle numbers are absolute; m_hs marks the AC handshake cycle.
    int           m_hs, m_cr_cyc, m_cd_cyc, m_data_cyc, m_upd_cyc, m_acr_cyc, m_cd_n;
    logic [4:0]   m_cr;
    logic [1:0]   m_upd_op;
    logic [127:0] m_cd_data;
    logic         m_cd_last;
    state_t       st_after_cr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        m_hs = -1; m_cr_cyc = -1; m_cd_cyc = -1; m_data_cyc = -1;
        m_upd_cyc = -1; m_acr_cyc = -1; m_cd_n = 0;
        m_cr = 5'b0; m_upd_op = 2'b0; m_cd_data = '0; m_cd_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.snoop_resp.cr_valid && m_cr_cyc < 0) begin
                m_cr_cyc = cyc;
                m_cr     = bus.snoop_resp.cr_resp;
            end
            if (bus.snoop_resp.cd_valid && bus.snoop_req.cd_ready) begin
                m_cd_n++;
                m_cd_data = bus.snoop_resp.cd.data;
                m_cd_last = bus.snoop_resp.cd.last;
                if (m_cd_cyc < 0) m_cd_cyc = cyc;
            end
            if (data_req && m_data_cyc < 0) m_data_cyc = cyc;
            if (upd_req && m_upd_cyc < 0) begin
                m_upd_cyc = cyc;
                m_upd_op  = upd_op;
            end
            if (bus.snoop_resp.ac_ready && m_acr_cyc < 0 && m_hs >= 0 && cyc > m_hs) m_acr_cyc = cyc;
        end
    end

    task automatic issue_ac(input string tag, input logic [3:0] code, input logic [63:0] addr);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.snoop_resp.ac_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.snoop_resp.ac_ready) check({tag, "_ac_ready_timeout"}, 0, 1);
        bus.snoop_req.ac.addr  = addr;
        bus.snoop_req.ac.snoop = code;
        bus.snoop_req.ac.prot  = 3'b010;
        bus.snoop_req.ac_valid = 1'b1;
        m_hs = cyc;
        @(negedge clk);
        bus.snoop_req.ac_valid = 1'b0;
        check({tag, "_addr"}, lookup_addr, addr);
    endtask

    task automatic run_snoop(input string tag, input logic [3:0] code, input logic [63:0] addr,
                             input logic hit, input logic dirty, input logic uniq,
                             input logic [127:0] data, input int cr_hold, input logic [4:0] exp_cr);
        int t;
        mon_clear();
        m_hit = hit; m_dirty = dirty; m_unique = uniq; m_data = data;
        issue_ac(tag, code, addr);
        t = 0;
        while (!bus.snoop_resp.cr_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.snoop_resp.cr_valid) begin
            check({tag, "_cr_timeout"}, 0, 1);
            return;
        end
        for (int i = 0; i < cr_hold; i++) begin
            check({tag, "_cr_hold"}, {bus.snoop_resp.cr_valid, bus.snoop_resp.cr_resp}, {1'b1, exp_cr});
            @(negedge clk);
        end
        bus.snoop_req.cr_ready = 1'b1;
        @(negedge clk);
        bus.snoop_req.cr_ready = 1'b0;
        st_after_cr = dbg_state;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (busy) check({tag, "_idle_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        bus.snoop_req = '0;
        bus.snoop_req.cd_ready = 1'b1;
        m_hit = 0; m_dirty = 0; m_unique = 0; m_data = '0;
        mon_clear();
        st_after_cr = ST_IDLE;

        #1;
        check("rst_ac_ready", bus.snoop_resp.ac_ready, 0);
        check("rst_outputs", {bus.snoop_resp.cr_valid, bus.snoop_resp.cd_valid, lookup_req,
                              data_req, upd_req, busy}, 6'b0);
        check("rst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ac_ready_rise", bus.snoop_resp.ac_ready, 1);

        // ReadUnique, dirty unique hit: CR = {1,0,1,0,1}
        run_snoop("ru", 4'b0111, 64'h0000_1000_0000_0040, 1, 1, 1, {16{8'hA5}}, 0, 5'b10101);
        check("ru_cr", m_cr, 5'b10101);
        check("ru_cr_lat", m_cr_cyc - m_hs, 4);
        check("ru_cd_lat", m_cd_cyc - m_hs, 5);
        check("ru_acr_lat", m_acr_cyc - m_hs, 6);
        check("ru_upd_op", m_upd_op, 2'b10);
        check("ru_order", (m_data_cyc >= 0) && (m_data_cyc < m_upd_cyc), 1);
        check("ru_cd_n", m_cd_n, 1);
        check("ru_cd_data", m_cd_data, {16{8'hA5}});
        check("ru_cd_last", m_cd_last, 1);
        check("ru_after_cr", st_after_cr, ST_CDATA);

        // ReadShared, clean shared hit: CR = {0,1,0,0,1}
        run_snoop("rs", 4'b0001, 64'h0000_2000_0000_0080, 1, 0, 0,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 5'b01001);
        check("rs_cr", m_cr, 5'b01001);
        check("rs_upd_op", m_upd_op, 2'b01);
        check("rs_order", (m_data_cyc >= 0) && (m_data_cyc < m_upd_cyc), 1);
        check("rs_cd_n", m_cd_n, 1);
        check("rs_cd_data", m_cd_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // MakeInvalid miss: CR = 0, nothing else
        run_snoop("mi", 4'b1101, 64'h0000_3000_0000_00C0, 0, 1, 1, 128'h1, 0, 5'b00000);
        check("mi_cr", m_cr, 5'b00000);
        check("mi_cr_lat", m_cr_cyc - m_hs, 2);
        check("mi_acr_lat", m_acr_cyc - m_hs, 3);
        check("mi_no_data", m_data_cyc, -1);
        check("mi_no_upd", m_upd_cyc, -1);
        check("mi_cd_n", m_cd_n, 0);

        // CleanShared, clean unique hit, CR held 5 cycles: CR = {1,1,0,0,0}
        run_snoop("cs", 4'b1000, 64'h0000_4000_0000_0100, 1, 0, 1, 128'h2, 5, 5'b11000);
        check("cs_cr", m_cr, 5'b11000);
        check("cs_no_data", m_data_cyc, -1);
        check("cs_upd_op", m_upd_op, 2'b01);
        check("cs_cd_n", m_cd_n, 0);
        check("cs_after_cr", st_after_cr, ST_IDLE);

        // CleanInvalid, dirty non-unique hit: CR = {0,0,1,0,1}
        run_snoop("ci", 4'b1001, 64'h0000_5000_0000_0140, 1, 1, 0, {8{16'hBEEF}}, 0, 5'b00101);
        check("ci_cr", m_cr, 5'b00101);
        check("ci_upd_op", m_upd_op, 2'b10);
        check("ci_order", (m_data_cyc >= 0) && (m_data_cyc < m_upd_cyc), 1);
        check("ci_cd_data", m_cd_data, {8{16'hBEEF}});

        // Reserved code on a dirty unique hit
`ifdef SNOOP_RESPONDER_ERR_EN
        run_snoop("rsv", 4'b0101, 64'h0000_6000_0000_0180, 1, 1, 1, 128'h3, 0, 5'b00010);
        check("rsv_cr", m_cr, 5'b00010);
`else
        run_snoop("rsv", 4'b0101, 64'h0000_6000_0000_0180, 1, 1, 1, 128'h3, 0, 5'b00000);
        check("rsv_cr", m_cr, 5'b00000);
`endif
        check("rsv_no_data", m_data_cyc, -1);
        check("rsv_no_upd", m_upd_cyc, -1);
        check("rsv_cd_n", m_cd_n, 0);

        // Reset while parked in CDATA
        mon_clear();
        m_hit = 1; m_dirty = 1; m_unique = 1; m_data = {16{8'h5A}};
        bus.snoop_req.cd_ready = 1'b0;
        bus.snoop_req.cr_ready = 1'b1;
        issue_ac("rst_cd", 4'b0111, 64'h0000_7000_0000_01C0);
        for (int t = 0; t < 20 && !bus.snoop_resp.cd_valid; t++) @(negedge clk);
        check("rst_cd_reached", bus.snoop_resp.cd_valid, 1);
        bus.snoop_req.cr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_cd_valid", bus.snoop_resp.cd_valid, 0);
        check("rst_cd_busy", busy, 0);
        check("rst_cd_ac_ready", bus.snoop_resp.ac_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.snoop_req.cd_ready = 1'b1;
        @(negedge clk);
        check("rst_cd_ac_ready_rise", bus.snoop_resp.ac_ready, 1);

        // ReadOnce after the abort: CR = {0,1,0,0,1}, no update
        run_snoop("ro", 4'b0000, 64'h0000_8000_0000_0200, 1, 0, 0, 128'hC0FFEE, 0, 5'b01001);
        check("ro_cr", m_cr, 5'b01001);
        check("ro_no_upd", m_upd_cyc, -1);
        check("ro_cd_data", m_cd_data, 128'hC0FFEE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
